// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Owner-state enum, memory top address, lock timeout, priority helper.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CPU_RD,
    DMA_RD,
    WR
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_CPU,
    OWN_DMA
  } owner_t;

  localparam logic [15:0] DMEM_TOP = 16'h0FFF;
  localparam int LOCK_TIMEOUT = 16;

  function automatic owner_t prioSel(
    input logic cpuReq,
    input logic dmaReq,
    input logic dmaFirst
  );
    owner_t o;
    o = OWN_NONE;
    if (dmaReq && dmaFirst) o = OWN_DMA;
    else if (cpuReq) o = OWN_CPU;
    else if (dmaReq) o = OWN_DMA;
    return o;
  endfunction

endpackage

// File: rtl/dmem_arbiter.sv
// CPU/DMA arbiter for the single-port d_ram, CPU priority with DMA starvation guard.
// Optional DMA burst lock enabled by defining DMEM_ARB_LOCK_EN.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 8,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
`ifdef DMEM_ARB_LOCK_EN
  input  logic              dma_lock,
`endif
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_dout
);

  state_t      state;
  state_t      stateNext;
  owner_t      own;
  logic [3:0]  waitCnt;
  logic        dmaForce;
  logic        dmaFirst;
  logic        dmaOor;

`ifdef DMEM_ARB_LOCK_EN
  logic        lastDma;
  logic [4:0]  lockCnt;
  logic        lockHold;
  logic        lockTo;

  // Lock keeps DMA ahead while it owned the last cycle, until timeout.
  always_comb begin
    lockTo   = (lockCnt == 5'(LOCK_TIMEOUT));
    lockHold = dma_lock & dma_req & lastDma & ~lockTo;
  end

  // Track DMA ownership and locked-grant run length.
  always_ff @(posedge clk) begin
    if (rst) begin
      lastDma <= 1'b0;
      lockCnt <= '0;
    end else begin
      lastDma <= dma_gnt & ~dmaOor;
      if (lockTo)
        lockCnt <= '0;
      else if (lockHold && dma_gnt)
        lockCnt <= lockCnt + 5'd1;
      else if (!(dma_lock && dma_req))
        lockCnt <= '0;
    end
  end
`endif

  // Grant selection and memory port steering.
  always_comb begin
    dmaForce  = (waitCnt == 4'(MAX_WAIT));
`ifdef DMEM_ARB_LOCK_EN
    dmaFirst  = dmaForce | lockHold;
`else
    dmaFirst  = dmaForce;
`endif
    own       = rst ? OWN_NONE
                    : prioSel(cpu_req, dma_req, dmaFirst);
    cpu_gnt   = (own == OWN_CPU);
    dma_gnt   = (own == OWN_DMA);
    dmaOor    = (dma_addr > ADDR_W'(DMEM_TOP));
    dma_err   = dma_gnt & dmaOor;
    mem_addr  = '0;
    mem_din   = '0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    stateNext = IDLE;
    if (cpu_gnt) begin
      mem_addr  = cpu_addr;
      mem_din   = cpu_wdata;
      mem_we    = cpu_we;
      mem_re    = ~cpu_we;
      stateNext = cpu_we ? WR : CPU_RD;
    end else if (dma_gnt && !dmaOor) begin
      mem_addr  = dma_addr;
      mem_din   = dma_wdata;
      mem_we    = dma_we;
      mem_re    = ~dma_we;
      stateNext = dma_we ? WR : DMA_RD;
    end
  end

  // Owner of the last cycle.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  // Count consecutive DMA denials, saturating at the force threshold.
  always_ff @(posedge clk) begin
    if (rst)
      waitCnt <= '0;
    else if (dma_req && !dma_gnt) begin
      if (!dmaForce) waitCnt <= waitCnt + 4'd1;
    end else
      waitCnt <= '0;
  end

  // Route registered read data to whoever issued the read.
  always_comb begin
    cpu_rvalid = ~rst & (state == CPU_RD);
    dma_rvalid = ~rst & (state == DMA_RD);
    cpu_rdata  = cpu_rvalid ? mem_dout : '0;
    dma_rdata  = dma_rvalid ? mem_dout : '0;
  end

endmodule
